load_store_unit: RTL and testbench

Initiator side of the byte-enabled data-memory interface: it sits between the core's execute stage and the data memory. It converts core loads and stores (byte/half/word, signed/unsigned) into word-aligned memory accesses with byte-lane masks and lane-shifted write data. It extracts and extends load data from memory read words. Accesses that straddle a word boundary are split into two sequential memory accesses.

---
 rtl/lsu_pkg.sv | 15 +
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the access-size encodings, the FSM state type and the word width in bytes.
package lsu_pkg;
    localparam logic [1:0]  SIZE_BYTE  = 2'd0;
    localparam logic [1:0]  SIZE_HALF  = 2'd1;
    localparam logic [1:0]  SIZE_WORD  = 2'd2;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_DONE
    } lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane math for the load/store unit.
// Builds the byte-lane masks and the shifted store data, and extracts/extends the load result.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [63:0] rd64,
    output logic [7:0]  mask8,
    output logic [63:0] wide64,
    output logic        crossing,
    output logic [31:0] rdata
);
    logic [7:0]  base_mask;
    logic [31:0] aligned;

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  sz,
                                                input logic        zext);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        b   = raw[7:0];
        h   = raw[15:0];
        ext = '0;
        case (sz)
            SIZE_BYTE: ext = zext ? $signed({24'd0, raw[7:0]})  : 32'(b);
            SIZE_HALF: ext = zext ? $signed({16'd0, raw[15:0]}) : 32'(h);
            SIZE_WORD: ext = $signed(raw);
            default:   ext = '0;
        endcase
        return ext;
    endfunction

    always_comb begin
        case (size)
            SIZE_BYTE: base_mask = 8'h01;
            SIZE_HALF: base_mask = 8'h03;
            SIZE_WORD: base_mask = 8'h0F;
            default:   base_mask = 8'h00;
        endcase
        mask8    = base_mask << off;
        wide64   = {32'd0, wdata} << {off, 3'b000};
        crossing = |mask8[7:4];
        // Bring the addressed byte down to lane 0 across the two-word window.
        aligned  = 32'(rd64 >> {off, 3'b000});
        rdata    = extend_load(aligned, size, is_unsigned);
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word accesses into word-aligned memory accesses,
// splitting word-crossing accesses into two back-to-back memory cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_bytes,
    output logic        mem_write,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout
);
    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        write_q;
    logic [31:0] lo;
    logic [31:0] hi;

    logic        idle;
    logic [1:0]  la_off;
    logic [1:0]  la_size;
    logic        la_uns;
    logic [31:0] la_wdata;
    logic [63:0] la_rd64;
    logic [7:0]  mask8;
    logic [63:0] wide64;
    logic        crossing;
    logic [31:0] ld_rdata;
    logic        bad_req;

    // In IDLE the lane math looks at the live request so the first access is ready at acceptance.
    always_comb begin
        idle     = (state == S_IDLE);
        la_off   = idle ? req_addr[1:0] : addr_q[1:0];
        la_size  = idle ? req_size      : size_q;
        la_uns   = idle ? req_unsigned  : uns_q;
        la_wdata = idle ? req_wdata     : wdata_q;
        la_rd64  = (state == S_SECOND) ? {mem_dataout, lo} : {hi, mem_dataout};
        bad_req  = (req_size == 2'd3) || (crossing && !ALLOW_MISALIGNED);
    end

    lsu_lane_align u_align (
        .off         (la_off),
        .size        (la_size),
        .is_unsigned (la_uns),
        .wdata       (la_wdata),
        .rd64        (la_rd64),
        .mask8       (mask8),
        .wide64      (wide64),
        .crossing    (crossing),
        .rdata       (ld_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            write_q    <= 1'b0;
            lo         <= '0;
            hi         <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_bytes  <= '0;
            mem_write  <= 1'b0;
            mem_datain <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        write_q   <= req_write;
                        lo        <= '0;
                        hi        <= '0;
                        req_ready <= 1'b0;
                        if (bad_req) begin
                            state      <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state      <= S_FIRST;
                            mem_addr   <= {req_addr[31:2], 2'b00};
                            mem_bytes  <= mask8[3:0];
                            mem_datain <= wide64[31:0];
                            mem_write  <= req_write;
                        end
                    end
                end
                S_FIRST: begin
                    if (!write_q) lo <= mem_dataout;
                    if (crossing) begin
                        state      <= S_SECOND;
                        mem_addr   <= mem_addr + WORD_BYTES;
                        mem_bytes  <= mask8[7:4];
                        mem_datain <= wide64[63:32];
                        mem_write  <= write_q;
                    end else begin
                        state      <= S_DONE;
                        mem_bytes  <= '0;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= write_q ? 32'd0 : ld_rdata;
                    end
                end
                S_SECOND: begin
                    if (!write_q) hi <= mem_dataout;
                    state      <= S_DONE;
                    mem_bytes  <= '0;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= write_q ? 32'd0 : ld_rdata;
                end
                default: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-enabled memory model.
// A second instance with ALLOW_MISALIGNED=0 covers the reject path.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid0;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_error, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_datain, mem_dataout;
    logic [3:0]  mem_bytes;

    logic        req_ready0, resp_valid0, resp_error0, mem_write0;
    logic [31:0] resp_rdata0, mem_addr0, mem_datain0, mem_dataout0;
    logic [3:0]  mem_bytes0;

    bit [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    int          lat, pulses, act;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] ob_addr  [1:5];
    logic [3:0]  ob_bytes [1:5];
    logic [31:0] ob_data  [1:5];
    logic        ob_wr    [1:5];
    logic        ob_rdy   [1:5];

    always #5 clk = ~clk;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_addr(mem_addr), .mem_bytes(mem_bytes),
        .mem_write(mem_write), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
        .resp_error(resp_error0), .mem_addr(mem_addr0), .mem_bytes(mem_bytes0),
        .mem_write(mem_write0), .mem_datain(mem_datain0), .mem_dataout(mem_dataout0)
    );

    assign mem_dataout  = mem[mem_addr[9:2]];
    assign mem_dataout0 = 32'h0;

    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 4; i++)
                if (mem_bytes[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_datain[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and record five cycles of DUT behaviour, sampled on falling edges.
    task automatic run_req(input bit sel, input logic wr, input logic [1:0] sz,
                           input logic un, input logic [31:0] ad, input logic [31:0] wd);
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = un; req_addr = ad; req_wdata = wd;
        if (sel) req_valid0 = 1'b1;
        else     req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        lat = 0; pulses = 0; act = 0; r_rdata = 'x; r_err = 1'bx;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            ob_addr[c]  = sel ? mem_addr0   : mem_addr;
            ob_bytes[c] = sel ? mem_bytes0  : mem_bytes;
            ob_data[c]  = sel ? mem_datain0 : mem_datain;
            ob_wr[c]    = sel ? mem_write0  : mem_write;
            ob_rdy[c]   = sel ? req_ready0  : req_ready;
            if (ob_wr[c] || ob_bytes[c] != 4'h0) act++;
            if (sel ? resp_valid0 : resp_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat     = c;
                    r_rdata = sel ? resp_rdata0 : resp_rdata;
                    r_err   = sel ? resp_error0 : resp_error;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; req_write = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_bytes", 32'(mem_bytes), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_datain", mem_datain, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Aligned word store
        run_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
        chk("sw_addr", ob_addr[1], 32'h100);
        chk("sw_bytes", 32'(ob_bytes[1]), 32'hF);
        chk("sw_data", ob_data[1], 32'hDEADBEEF);
        chk("sw_write", 32'(ob_wr[1]), 32'd1);
        chk("sw_ready_busy", 32'(ob_rdy[1]), 32'd0);
        chk("sw_write_after", 32'(ob_wr[2]), 32'd0);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_err", 32'(r_err), 32'd0);
        chk("sw_rdata", r_rdata, 32'd0);
        chk("sw_pulses", 32'(pulses), 32'd1);

        // Loads from 0xDEADBEEF
        run_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        chk("lb_103", r_rdata, 32'hFFFFFFDE);
        chk("lb_lat", 32'(lat), 32'd2);
        run_req(1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        chk("lbu_103", r_rdata, 32'h000000DE);
        run_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        chk("lh_102", r_rdata, 32'hFFFFDEAD);
        run_req(1'b0, 1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
        chk("lhu_100", r_rdata, 32'h0000BEEF);
        chk("lhu_err", 32'(r_err), 32'd0);

        // Misaligned half inside one word
        run_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h1234);
        chk("sh_bytes", 32'(ob_bytes[1]), 32'h6);
        chk("sh_data", ob_data[1], 32'h00123400);
        chk("sh_second_bytes", 32'(ob_bytes[2]), 32'h0);
        chk("sh_lat", 32'(lat), 32'd2);
        run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("lw_after_sh", r_rdata, 32'hDE1234EF);

        // Word store crossing into the next word
        run_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h103, 32'hAABBCCDD);
        chk("swx_addr1", ob_addr[1], 32'h100);
        chk("swx_bytes1", 32'(ob_bytes[1]), 32'h8);
        chk("swx_data1", ob_data[1], 32'hDD000000);
        chk("swx_addr2", ob_addr[2], 32'h104);
        chk("swx_bytes2", 32'(ob_bytes[2]), 32'h7);
        chk("swx_data2", ob_data[2], 32'h00AABBCC);
        chk("swx_write2", 32'(ob_wr[2]), 32'd1);
        chk("swx_lat", 32'(lat), 32'd3);
        run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h103, 32'h0);
        chk("lwx_rdata", r_rdata, 32'hAABBCCDD);
        chk("lwx_lat", 32'(lat), 32'd3);

        // Address wrap and reject paths
        run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
        chk("wrap_addr1", ob_addr[1], 32'hFFFFFFFC);
        chk("wrap_bytes1", 32'(ob_bytes[1]), 32'hC);
        chk("wrap_addr2", ob_addr[2], 32'h00000000);
        chk("wrap_bytes2", 32'(ob_bytes[2]), 32'h3);
        chk("wrap_lat", 32'(lat), 32'd3);
        run_req(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
        chk("nomis_lat", 32'(lat), 32'd1);
        chk("nomis_err", 32'(r_err), 32'd1);
        chk("nomis_rdata", r_rdata, 32'd0);
        chk("nomis_memact", 32'(act), 32'd0);
        chk("nomis_pulses", 32'(pulses), 32'd1);
        run_req(1'b1, 1'b1, 2'd1, 1'b0, 32'h103, 32'h5555);
        chk("nomis_sh_err", 32'(r_err), 32'd1);
        chk("nomis_sh_memact", 32'(act), 32'd0);
        run_req(1'b0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        chk("size3_lat", 32'(lat), 32'd1);
        chk("size3_err", 32'(r_err), 32'd1);
        chk("size3_memact", 32'(act), 32'd0);

        // Reset while the second half of a crossing store is on the bus
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h106; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_write", 32'(mem_write), 32'd1);
        chk("abort_pre_addr", mem_addr, 32'h108);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_write_drop", 32'(mem_write), 32'd0);
        chk("abort_bytes_drop", 32'(mem_bytes), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        chk("abort_no_resp", 32'(pulses), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        chk("abort_half_written", r_rdata, 32'h3344BBCC);
        chk("abort_next_lat", 32'(lat), 32'd2);
        run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h108, 32'h0);
        chk("abort_second_unwritten", r_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
